// File: rtl/dh_shared_key.sv
// Diffie-Hellman shared key engine: key = r_in^y mod p via constant-time
// square-and-multiply built on a bit-serial interleaved modular multiplier.
module dh_shared_key (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] p,
  input  logic [31:0] y,
  input  logic [31:0] r_in,
  input  logic        r_valid,
  output logic        r_ready,
  output logic [31:0] key,
  output logic        key_valid,
  output logic        err,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RED,
    S_SQR,
    S_MUL,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [31:0] r_p;
  logic [31:0] r_y;
  logic [31:0] r_rin;
  logic [31:0] r_base;
  logic [31:0] r_res;
  logic [31:0] r_t;
  logic [4:0]  r_bit;
  logic [4:0]  r_idx;

  logic        w_accept;
  logic        w_last;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [32:0] w_dbl;
  logic [32:0] w_dbl_red;
  logic [32:0] w_sum;
  logic [32:0] w_sum_red;
  logic [31:0] w_t_next;

  // key_valid cycle still counts as busy, so the next accept lands one cycle later
  assign r_ready  = (r_state == S_IDLE) && !key_valid;
  assign busy     = !r_ready;
  assign w_accept = r_valid && r_ready;
  assign w_last   = (r_bit == 5'd0);

  always_comb begin
    w_a = '0;
    w_b = '0;
    case (r_state)
      S_RED: begin
        w_a = r_rin;
        w_b = 32'd1;
      end
      S_SQR: begin
        w_a = r_res;
        w_b = r_res;
      end
      S_MUL: begin
        w_a = r_res;
        w_b = r_y[r_idx] ? r_base : 32'd1;
      end
      default: ;
    endcase
  end

  // One multiplier step: t < p and b < p keep both partial values below 2p
  always_comb begin
    w_dbl     = {r_t, 1'b0};
    w_dbl_red = (w_dbl >= {1'b0, r_p}) ? (w_dbl - {1'b0, r_p}) : w_dbl;
    w_sum     = w_dbl_red + {1'b0, w_b};
    w_sum_red = (w_sum >= {1'b0, r_p}) ? (w_sum - {1'b0, r_p}) : w_sum;
    w_t_next  = w_a[r_bit] ? w_sum_red[31:0] : w_dbl_red[31:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = (p < 32'd2) ? S_DONE : S_RED;
      S_RED:  if (w_last) w_next = S_SQR;
      S_SQR:  if (w_last) w_next = S_MUL;
      S_MUL:  if (w_last) w_next = (r_idx == 5'd0) ? S_DONE : S_SQR;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_p       <= '0;
      r_y       <= '0;
      r_rin     <= '0;
      r_base    <= '0;
      r_res     <= '0;
      r_t       <= '0;
      r_bit     <= '0;
      r_idx     <= '0;
      key       <= '0;
      key_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_p   <= p;
            r_y   <= y;
            r_rin <= r_in;
            r_res <= 32'd1;
            r_idx <= 5'd31;
            r_bit <= 5'd31;
            r_t   <= '0;
          end
        end
        S_RED, S_SQR, S_MUL: begin
          // r_bit wraps from 0 back to 31, ready for the next pass
          r_bit <= r_bit - 5'd1;
          if (w_last) begin
            r_t <= '0;
            if (r_state == S_RED) r_base <= w_t_next;
            else                  r_res  <= w_t_next;
            if (r_state == S_MUL) r_idx <= r_idx - 5'd1;
          end else begin
            r_t <= w_t_next;
          end
        end
        S_DONE: begin
          key       <= (r_p < 32'd2) ? '0 : r_res;
          err       <= (r_p < 32'd2);
          key_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dh_shared_key.sv
// Scoreboard bench for dh_shared_key: expected keys are queued at accept and
// compared against key/err/latency when key_valid pulses.
module tb_dh_shared_key;

  logic        clk;
  logic        rst;
  logic [31:0] p;
  logic [31:0] y;
  logic [31:0] r_in;
  logic        r_valid;
  logic        r_ready;
  logic [31:0] key;
  logic        key_valid;
  logic        err;
  logic        busy;

  dh_shared_key dut (
    .clk       (clk),
    .rst       (rst),
    .p         (p),
    .y         (y),
    .r_in      (r_in),
    .r_valid   (r_valid),
    .r_ready   (r_ready),
    .key       (key),
    .key_valid (key_valid),
    .err       (err),
    .busy      (busy)
  );

  typedef struct {
    logic [31:0] key;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp;
  int          n_err;
  int          cyc;
  int          n_acc;
  logic [31:0] last_key;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_pow(input logic [31:0] pp, input logic [31:0] yy,
                                          input logic [31:0] rr);
    longint unsigned m, b, acc;
    if (pp < 2) return '0;
    m   = pp;
    b   = rr % m;
    acc = 1;
    for (int i = 31; i >= 0; i--) begin
      acc = (acc * acc) % m;
      if (yy[i]) acc = (acc * b) % m;
    end
    return acc[31:0];
  endfunction

  function automatic bit is_prime(input longint unsigned n);
    if (n < 2) return 1'b0;
    if (n % 2 == 0) return n == 2;
    for (longint unsigned d = 3; d * d <= n; d += 2)
      if (n % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rst && r_valid && r_ready) n_acc++;
    if (key_valid) begin
      if (sb.size() == 0) begin
        check("spurious_kv", 1, 0);
      end else begin
        e = sb.pop_front();
        check("key", key, e.key);
        check("err", err, e.err);
        check("latency", cyc - e.acc + 1, e.lat);
        check("busy_at_kv", busy, 1);
        last_key = e.key;
      end
    end
  end

  // Leaves r_valid high so consecutive calls run back-to-back.
  task automatic send(input logic [31:0] pp, input logic [31:0] yy, input logic [31:0] rr);
    exp_t e;
    int   n;
    @(negedge clk);
    p       = pp;
    y       = yy;
    r_in    = rr;
    r_valid = 1'b1;
    n       = 0;
    while (!r_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!r_ready) begin
      check("accept_timeout", 0, 1);
    end else begin
      e.key = ref_pow(pp, yy, rr);
      e.err = (pp < 2);
      e.acc = cyc + 1;
      e.lat = (pp < 2) ? 2 : 2082;
      sb.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic drain();
    int n;
    @(negedge clk);
    r_valid = 1'b0;
    n = 0;
    while (sb.size() > 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 0);
  endtask

  initial begin
    logic [31:0] rp;
    int          a0;
    n_cmp    = 0;
    n_err    = 0;
    cyc      = 0;
    n_acc    = 0;
    last_key = '0;
    rst      = 1'b0;
    p        = '0;
    y        = '0;
    r_in     = '0;
    r_valid  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_r_ready", r_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_key", key, 0);
    check("rst_key_valid", key_valid, 0);
    check("rst_err", err, 0);
    rst = 1'b1;

    send(23, 15, 8);
    drain();
    repeat (3) @(negedge clk);
    check("key_hold", key, last_key);

    send(5, 6, 17);
    send(23, 15, 31);
    send(23, 0, 19);
    send(23, 6, 0);
    send(1, 32'hDEAD_BEEF, 32'h1234_5678);
    send(23, 6, 19);
    send(0, 5, 5);
    send(32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 20; i++) begin
      do rp = $urandom | 32'd1; while (!is_prime(rp));
      send(rp, $urandom, $urandom);
    end
    drain();

    // Abort mid-computation; r_valid stays high throughout, including the reset cycle
    send(23, 15, 8);
    a0 = n_acc;
    repeat (498) @(negedge clk);
    check("busy_mid", busy, 1);
    rst = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    check("abort_r_ready", r_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_key", key, 0);
    check("abort_err", err, 0);
    check("no_2nd_accept", n_acc, a0);
    r_valid = 1'b0;
    rst     = 1'b1;
    repeat (1700) @(negedge clk);
    check("abort_key_after", key, 0);
    check("abort_no_accept", n_acc, a0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
